// File: rtl/echo_delay_pkg.sv
// echo_delay_pkg: shared types, defaults and saturation helper for the audio output chain
package echo_delay_pkg;
  typedef enum logic [2:0] {CLEAR, IDLE, READ, MUL, WRITE} echo_state_t;
  localparam int ECHO_DEPTH_DEFAULT = 4800;
  // Clamp a wide signed value into the signed range of w bits; caller truncates the result.
  function automatic logic signed [63:0] saturate(input logic signed [63:0] x, input int w);
    logic signed [63:0] hi, lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    return x > hi ? hi : x < lo ? lo : x;
  endfunction
endpackage

// File: rtl/echo_delay_ram.sv
// echo_delay_ram: simple dual-port WIDTH x DEPTH delay line, 1-cycle synchronous read
// Ports: clk, we/waddr/wdata write port, raddr/rdata read port.
module echo_delay_ram #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 4800
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);
  logic [WIDTH-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end
endmodule

// File: rtl/echo_delay.sv
// echo_delay: feedback echo with dry/wet mix over a circular delay line, one sample per strobe
// Ports: clk, rst (sync, active-high); sample_valid/in input sample; delay_len, dry_gain,
// wet_gain, feedback controls (gains signed Q.FRAC); out/out_valid mixed sample; overrun sticky.
// Macro ECHO_CLEAR_EN: zero the delay line for DEPTH cycles after reset (dry-only output meanwhile).
module echo_delay import echo_delay_pkg::*; #(
  parameter int WIDTH = 24,
  parameter int DEPTH = ECHO_DEPTH_DEFAULT,
  parameter int FRAC  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     sample_valid,
  input  logic signed [WIDTH-1:0]  in,
  input  logic [$clog2(DEPTH)-1:0] delay_len,
  input  logic signed [31:0]       dry_gain,
  input  logic signed [31:0]       wet_gain,
  input  logic signed [31:0]       feedback,
  output logic signed [WIDTH-1:0]  out,
  output logic                     out_valid,
  output logic                     overrun
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = WIDTH + 32;
  localparam int SW = WIDTH + 33;
  localparam logic [AW-1:0] DMAX = AW'(DEPTH - 1);
  localparam logic signed [31:0] FB_MAX = (32'sd1 <<< FRAC) - 32'sd1;
`ifdef ECHO_CLEAR_EN
  localparam echo_state_t RST_STATE = CLEAR;
`else
  localparam echo_state_t RST_STATE = IDLE;
`endif
  echo_state_t state;
  logic [AW-1:0] wr_ptr, next_ptr, dl_r, d, raddr;
  logic signed [WIDTH-1:0] in_r, rdata, tap, wdata, out_mix;
  logic signed [31:0] dry_r, wet_r, fb_r;
  logic signed [PW-1:0] p_dry, p_wet, p_fb;
  logic signed [SW-1:0] mix, fbw;
  logic we;
  assign d        = dl_r > DMAX ? DMAX : dl_r;
  assign raddr    = wr_ptr >= d ? wr_ptr - d : AW'((AW+1)'(wr_ptr) + (AW+1)'(DEPTH) - (AW+1)'(d));
  assign next_ptr = wr_ptr == DMAX ? '0 : wr_ptr + AW'(1);
  assign tap      = d == '0 ? '0 : rdata;
  assign mix      = (SW'(p_dry) + SW'(p_wet)) >>> FRAC;
  assign fbw      = SW'(in_r) + (SW'(p_fb) >>> FRAC);
  assign out_mix  = WIDTH'(saturate(64'(mix), WIDTH));
  // Reset gates the write so an aborted sample never reaches the line.
  assign we       = !rst && (state == WRITE || state == CLEAR);
  assign wdata    = state == CLEAR ? '0 : WIDTH'(saturate(64'(fbw), WIDTH));
`ifdef ECHO_CLEAR_EN
  logic signed [PW-1:0] p_in;
  logic signed [WIDTH-1:0] out_dry;
  assign p_in    = in * dry_gain;
  assign out_dry = WIDTH'(saturate(64'(p_in >>> FRAC), WIDTH));
`endif
  echo_delay_ram #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_ram (
    .clk  (clk),
    .we   (we),
    .waddr(wr_ptr),
    .wdata(wdata),
    .raddr(raddr),
    .rdata(rdata)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RST_STATE;
      wr_ptr    <= '0;
      out       <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (state)
`ifdef ECHO_CLEAR_EN
        CLEAR: begin
          wr_ptr <= next_ptr;
          if (wr_ptr == DMAX) state <= IDLE;
          if (sample_valid) begin
            out       <= out_dry;
            out_valid <= 1'b1;
          end
        end
`endif
        IDLE: if (sample_valid) begin
          in_r  <= in;
          dl_r  <= delay_len;
          dry_r <= dry_gain;
          wet_r <= wet_gain;
          fb_r  <= feedback > FB_MAX ? FB_MAX : feedback;
          state <= READ;
        end
        READ: state <= MUL;
        MUL: begin
          p_dry <= in_r * dry_r;
          p_wet <= tap * wet_r;
          p_fb  <= tap * fb_r;
          state <= WRITE;
        end
        WRITE: begin
          out       <= out_mix;
          out_valid <= 1'b1;
          wr_ptr    <= next_ptr;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
      if (sample_valid && (state == READ || state == MUL || state == WRITE)) overrun <= 1'b1;
    end
  end
endmodule

// File: tb/tb_echo_delay.sv
// tb_echo_delay: randomized self-checking bench for echo_delay against a sample-level model
module tb_echo_delay;
  localparam int WIDTH = 24;
  localparam int DEPTH = 16;
  localparam int FRAC  = 16;
  localparam longint MAXV = 8388607;
  localparam longint MINV = -8388608;
  logic clk = 0;
  logic rst;
  logic sample_valid;
  logic signed [WIDTH-1:0] in;
  logic [3:0] delay_len;
  logic signed [31:0] dry_gain, wet_gain, feedback;
  logic signed [WIDTH-1:0] out;
  logic out_valid, overrun;
  int checks = 0;
  int errors = 0;
  longint line [DEPTH];
  int wp;
  echo_delay #(.WIDTH(WIDTH), .DEPTH(DEPTH), .FRAC(FRAC)) dut (
    .clk         (clk),
    .rst         (rst),
    .sample_valid(sample_valid),
    .in          (in),
    .delay_len   (delay_len),
    .dry_gain    (dry_gain),
    .wet_gain    (wet_gain),
    .feedback    (feedback),
    .out         (out),
    .out_valid   (out_valid),
    .overrun     (overrun)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  function automatic longint sat(input longint v);
    return v > MAXV ? MAXV : v < MINV ? MINV : v;
  endfunction
  // One sample through the echo: read tap d samples back, mix, write input plus scaled tap.
  function automatic longint model(input longint x, input longint dl, input longint dry, input longint wet, input longint fb);
    longint d, tap, f, o;
    d   = dl > DEPTH - 1 ? DEPTH - 1 : dl;
    tap = d == 0 ? 0 : line[(wp - d + DEPTH) % DEPTH];
    f   = fb > 65535 ? 65535 : fb;
    o   = sat((x * dry + tap * wet) >>> FRAC);
    line[wp] = sat(x + ((tap * f) >>> FRAC));
    wp = (wp + 1) % DEPTH;
    return o;
  endfunction
  task automatic scramble();
    in        = 24'($urandom);
    delay_len = 4'($urandom);
    dry_gain  = 32'($urandom);
    wet_gain  = 32'($urandom);
    feedback  = 32'($urandom);
  endtask
  task automatic strobe(input string tag, input int x, input int dl, input int dry, input int wet, input int fb);
    longint exp;
    logic seen;
    exp = model(x, dl, dry, wet, fb);
    sample_valid = 1; in = 24'(x); delay_len = 4'(dl);
    dry_gain = dry; wet_gain = wet; feedback = fb;
    @(negedge clk);
    sample_valid = 0;
    scramble();
    seen = out_valid;
    repeat (2) begin
      @(negedge clk);
      seen |= out_valid;
    end
    check({tag, "_early"}, seen, 0);
    @(negedge clk);
    check({tag, "_valid"}, out_valid, 1);
    check(tag, out, exp);
    @(negedge clk);
    check({tag, "_pulse"}, out_valid, 0);
    repeat (3) @(negedge clk);
    check({tag, "_hold"}, out, exp);
  endtask
  task automatic model_reset();
    wp = 0;
`ifdef ECHO_CLEAR_EN
    for (int i = 0; i < DEPTH; i++) line[i] = 0;
`endif
  endtask
  initial begin
    logic seen;
    longint exp;
    for (int i = 0; i < DEPTH; i++) line[i] = 0;
    wp = 0;
    rst = 1; sample_valid = 0; in = 0; delay_len = 0;
    dry_gain = 0; wet_gain = 0; feedback = 0;
    repeat (3) @(negedge clk);
    check("rst_out", out, 0);
    check("rst_valid", out_valid, 0);
    check("rst_overrun", overrun, 0);
`ifdef ECHO_CLEAR_EN
    rst = 0; sample_valid = 1; in = 77; dry_gain = 65536; wet_gain = 65536;
    @(negedge clk);
    sample_valid = 0;
    check("clear_valid", out_valid, 1);
    check("clear_out", out, 77);
    @(negedge clk);
    check("clear_pulse", out_valid, 0);
    check("clear_overrun", overrun, 0);
    repeat (DEPTH) @(negedge clk);
    for (int i = 1; i < DEPTH; i++) strobe("clear_tap", 0, i, 0, 65536, 0);
`else
    rst = 0;
    for (int i = 0; i < DEPTH; i++) strobe("prime", 0, 0, 0, 0, 0);
`endif
    strobe("imp", 1000, 4, 65536, 32768, 0);
    for (int i = 1; i < 8; i++) strobe("imp", 0, 4, 65536, 32768, 0);
    strobe("imp_fb", 1000, 4, 65536, 32768, 32768);
    for (int i = 1; i < 16; i++) strobe("imp_fb", 0, 4, 65536, 32768, 32768);
    strobe("sat_hi", 8388607, 1, 65536, 65536, 0);
    strobe("sat_hi", 8388607, 1, 65536, 65536, 0);
    strobe("sat_lo", -8388608, 1, 65536, 65536, 0);
    strobe("sat_lo", -8388608, 1, 65536, 65536, 0);
    for (int i = 0; i < 3; i++) strobe("dl_zero", int'($urandom_range(16777215)) - 8388608, 0, 65536, 65536, 65535);
    for (int i = 0; i < 4; i++) strobe("dl_max", int'($urandom_range(2000000)) - 1000000, 15, 40000, 50000, 30000);
    for (int i = 0; i < 8; i++) strobe("fb_clamp", int'($urandom_range(200000)) - 100000, 2, 30000, 65536, 32'h00020000);
    for (int i = 0; i < 40; i++)
      strobe("rand", int'($urandom_range(16777215)) - 8388608, int'($urandom_range(15)),
             int'($urandom_range(262143)) - 131072, int'($urandom_range(262143)) - 131072,
             int'($urandom_range(196607)) - 65536);
    exp = model(5000, 3, 65536, 0, 0);
    sample_valid = 1; in = 5000; delay_len = 3; dry_gain = 65536; wet_gain = 0; feedback = 0;
    @(negedge clk);
    sample_valid = 0;
    check("ovr_before", overrun, 0);
    @(negedge clk);
    sample_valid = 1; in = 1234; delay_len = 0; dry_gain = 65536;
    @(negedge clk);
    sample_valid = 0;
    check("ovr_set", overrun, 1);
    @(negedge clk);
    check("ovr_valid", out_valid, 1);
    check("ovr_out", out, exp);
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      seen |= out_valid;
    end
    check("ovr_ignored", seen, 0);
    check("ovr_held", overrun, 1);
    sample_valid = 1; in = 3000; delay_len = 5; dry_gain = 65536; wet_gain = 65536; feedback = 65535;
    @(negedge clk);
    sample_valid = 0;
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    model_reset();
    check("mid_rst_out", out, 0);
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_overrun", overrun, 0);
    seen = 0;
    repeat (DEPTH + 1) begin
      @(negedge clk);
      seen |= out_valid;
    end
    check("mid_rst_no_valid", seen, 0);
    for (int i = 0; i < 10; i++)
      strobe("post_rst", int'($urandom_range(2000000)) - 1000000, int'($urandom_range(15)),
             int'($urandom_range(131071)) - 65536, int'($urandom_range(131071)) - 65536,
             int'($urandom_range(131071)) - 65536);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
